// File: rtl/dct_pkg.sv
// Shared constants and FSM state encoding for the DCT transpose controller.
package dct_pkg;

    // Columns (and rows) per transpose block.
    localparam int DCT_N     = 8;
    localparam int DCT_IDX_W = $clog2(DCT_N);

    // Two-state sequencer: FILL writes columns into the bank, DRAIN reads rows out.
    typedef logic [0:0] state_t;
    localparam state_t FILL  = 1'b0;
    localparam state_t DRAIN = 1'b1;

endpackage

// File: rtl/dct_onehot_dec.sv
// Enabled binary-to-one-hot decoder that selects one column of the stage-2 bank.
module dct_onehot_dec
    import dct_pkg::*;
#(
    parameter int N = DCT_N
) (
    input  logic                 en_i,
    input  logic [$clog2(N)-1:0] sel_i,
    output logic [N-1:0]         onehot_o
);

    // Drive the selected bit only when enabled; all-zero otherwise.
    always_comb begin
        // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
        onehot_o = '0;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/dct_transpose_ctrl.sv
// Sequencer for the stage-2 transpose flip-flop bank: fills eight columns,
// then presents eight rows to stage 3, counting completed blocks.
module dct_transpose_ctrl
    import dct_pkg::*;
#(
    parameter int N     = DCT_N,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     wr_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_row,
    output logic             out_last,
    output logic [CNT_W-1:0] blk_cnt
);

    state_t                  state_q, state_d;
    logic [DCT_IDX_W-1:0]    col_cnt_q, col_cnt_d;
    logic [DCT_IDX_W-1:0]    row_cnt_q, row_cnt_d;
    logic [CNT_W-1:0]        blk_cnt_q, blk_cnt_d;
    logic                    col_acc;
    logic                    row_acc;

    localparam logic [DCT_IDX_W-1:0] LAST_IDX = DCT_IDX_W'(DCT_N - 1);

    // Handshake outputs; a flush cycle blocks both sides of the bank.
    always_comb begin
        in_ready  = (state_q == FILL)  && !flush;
        out_valid = (state_q == DRAIN) && !flush;
        col_acc   = in_valid && in_ready;
        row_acc   = out_valid && out_ready;
        out_row   = row_cnt_q;
        out_last  = out_valid && (row_cnt_q == LAST_IDX);
        blk_cnt   = blk_cnt_q;
    end

    // Column write strobe: one-hot on the current column, only on acceptance.
    dct_onehot_dec #(
        .N (N)
    ) u_wr_dec (
        .en_i     (col_acc),
        .sel_i    (col_cnt_q),
        .onehot_o (wr_en)
    );

    // Next-state logic: flush first, then column acceptance, then row acceptance.
    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        blk_cnt_d = blk_cnt_q;
        if (flush) begin
            state_d   = FILL;
            col_cnt_d = '0;
            row_cnt_d = '0;
        end else if (col_acc) begin
            if (col_cnt_q == LAST_IDX) begin
                // Last column lands at this edge, so DRAIN starts on a full bank.
                state_d   = DRAIN;
                col_cnt_d = '0;
                row_cnt_d = '0;
            end else begin
                col_cnt_d = col_cnt_q + 1'b1;
            end
        end else if (row_acc) begin
            if (row_cnt_q == LAST_IDX) begin
                state_d   = FILL;
                row_cnt_d = '0;
                blk_cnt_d = blk_cnt_q + CNT_W'(1);
            end else begin
                row_cnt_d = row_cnt_q + 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset; reset outranks flush.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst) begin
            state_q   <= FILL;
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            blk_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

endmodule
